// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    localparam logic M_CPU = 1'b0;
    localparam logic M_AUX = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input grant selector: round-robin on ties, or master 0 first when fixed_prio is set.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed_prio,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        grant = M_CPU;
        if (req == 2'b11) begin
            grant = fixed_prio ? M_CPU : ~last;
        end else if (req[1]) begin
            grant = M_AUX;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter and single-access sequencer for the single-port data memory.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DEPTH      = 101,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_dataIn,
    output logic        mem_memRead,
    output logic        mem_memWrite,
    input  logic [31:0] mem_dataOut,
    output logic        busy,
    output logic        grant_id
);

    state_t              state_q, state_n;
    logic                id_q, we_q, err_q, rr_last_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q;

    logic                win_id, win_valid;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    rr_arb2 u_arb (
        .req        ({m1_req, m0_req}),
        .last       (rr_last_q),
        .fixed_prio (FIXED_PRIO),
        .grant      (win_id),
        .valid      (win_valid)
    );

    assign sel_we    = (win_id == M_AUX) ? m1_we    : m0_we;
    assign sel_addr  = (win_id == M_AUX) ? m1_addr  : m0_addr;
    assign sel_wdata = (win_id == M_AUX) ? m1_wdata : m0_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (win_valid) state_n = ACCESS;
            ACCESS:  state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Request fields are captured only in IDLE so masters may change them freely afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q      <= M_CPU;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rr_last_q <= M_AUX;
        end else begin
            if (state_q == IDLE && win_valid) begin
                id_q      <= win_id;
                we_q      <= sel_we;
                addr_q    <= sel_addr;
                wdata_q   <= sel_wdata;
                err_q     <= (sel_addr >= ADDR_W'(DEPTH));
                rr_last_q <= win_id;
            end
            if (state_q == ACCESS) begin
                rdata_q <= (!we_q && !err_q) ? mem_dataOut : '0;
            end
        end
    end

    always_comb begin
        mem_address  = '0;
        mem_dataIn   = '0;
        mem_memRead  = 1'b0;
        mem_memWrite = 1'b0;
        m0_ack       = 1'b0;
        m0_rdata     = '0;
        m0_err       = 1'b0;
        m1_ack       = 1'b0;
        m1_rdata     = '0;
        m1_err       = 1'b0;
        busy         = (state_q != IDLE);
        grant_id     = (state_q != IDLE) ? id_q : M_CPU;
        case (state_q)
            ACCESS: begin
                mem_address  = addr_q;
                mem_dataIn   = wdata_q;
                mem_memRead  = !we_q && !err_q;
                mem_memWrite = we_q && !err_q;
            end
            DONE: begin
                if (id_q == M_AUX) begin
                    m1_ack   = 1'b1;
                    m1_rdata = rdata_q;
                    m1_err   = err_q;
                end else begin
                    m0_ack   = 1'b1;
                    m0_rdata = rdata_q;
                    m0_err   = err_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 101-word memory.
module tb_dmem_arbiter;

    logic        clk, rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_address, mem_dataIn, mem_dataOut;
    logic        mem_memRead, mem_memWrite, busy, grant_id;

    logic        fp_m0_ack, fp_m0_err, fp_m1_ack, fp_m1_err;
    logic [31:0] fp_m0_rdata, fp_m1_rdata;
    logic [31:0] fp_mem_address, fp_mem_dataIn, fp_mem_dataOut;
    logic        fp_mem_memRead, fp_mem_memWrite, fp_busy, fp_grant_id;

    logic [31:0] mem [0:100];
    logic        pl_en;
    logic [6:0]  pl_addr;
    logic [31:0] pl_data;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.DEPTH(101), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_address(mem_address), .mem_dataIn(mem_dataIn),
        .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
        .mem_dataOut(mem_dataOut), .busy(busy), .grant_id(grant_id)
    );

    dmem_arbiter #(.DEPTH(101), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(fp_m0_ack), .m0_rdata(fp_m0_rdata), .m0_err(fp_m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(fp_m1_ack), .m1_rdata(fp_m1_rdata), .m1_err(fp_m1_err),
        .mem_address(fp_mem_address), .mem_dataIn(fp_mem_dataIn),
        .mem_memRead(fp_mem_memRead), .mem_memWrite(fp_mem_memWrite),
        .mem_dataOut(fp_mem_dataOut), .busy(fp_busy), .grant_id(fp_grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory is written only by the main instance; the fixed-priority copy only reads.
    assign mem_dataOut    = (mem_address < 32'd101) ? mem[mem_address[6:0]] : 32'd0;
    assign fp_mem_dataOut = (fp_mem_address < 32'd101) ? mem[fp_mem_address[6:0]] : 32'd0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_memWrite && mem_address < 32'd101) mem[mem_address[6:0]] <= mem_dataIn;
    end

    typedef struct {
        logic        mst;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic preload(input logic [6:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        @(negedge clk);
        if (v.mst) begin
            m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata;
        end else begin
            m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata;
        end
        @(posedge clk); #1;
        chk("access_busy", busy, 1);
        chk("access_grant_id", grant_id, v.mst);
        chk("access_address", mem_address, v.addr);
        chk("access_dataIn", mem_dataIn, v.wdata);
        chk("access_memRead", mem_memRead, !v.we && !v.exp_err);
        chk("access_memWrite", mem_memWrite, v.we && !v.exp_err);
        @(posedge clk); #1;
        chk("done_m0_ack", m0_ack, !v.mst);
        chk("done_m1_ack", m1_ack, v.mst);
        chk("done_rdata", v.mst ? m1_rdata : m0_rdata, v.exp_rdata);
        chk("done_err", v.mst ? m1_err : m0_err, v.exp_err);
        chk("done_other_rdata", v.mst ? m0_rdata : m1_rdata, 0);
        chk("done_memWrite", mem_memWrite, 0);
        chk("done_address", mem_address, 0);
        m0_req = 1'b0; m1_req = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);
        chk("idle_acks", {m0_ack, m1_ack}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;

        vecs[0] = '{1'b0, 1'b0, 32'd80,         32'd0,          32'd8,          1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'd5,          32'hDEADBEEF,   32'd0,          1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'd5,          32'd0,          32'hDEADBEEF,   1'b0};
        vecs[3] = '{1'b0, 1'b1, 32'd101,        32'h1234,       32'd0,          1'b1};
        vecs[4] = '{1'b0, 1'b0, 32'hFFFFFFFF,   32'd0,          32'd0,          1'b1};
        vecs[5] = '{1'b1, 1'b0, 32'd100,        32'd0,          32'h55,         1'b0};
        vecs[6] = '{1'b0, 1'b0, 32'd101,        32'd0,          32'd0,          1'b1};
        vecs[7] = '{1'b0, 1'b1, 32'd0,          32'h0000A5A5,   32'd0,          1'b0};
        vecs[8] = '{1'b1, 1'b0, 32'd0,          32'd0,          32'h0000A5A5,   1'b0};

        preload(7'd80, 32'd8);
        preload(7'd81, 32'd44);
        preload(7'd83, 32'hFFFFFF86);
        preload(7'd100, 32'h55);
        preload(7'd10, 32'd7);

        // Reset held with a pending request
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd80;
        for (int unsigned i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_busy", busy, 0);
            chk("rst_outputs", {m0_ack, m1_ack, m0_err, m1_err, mem_memRead, mem_memWrite, grant_id}, 0);
            chk("rst_address", mem_address, 0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_busy", busy, 1);
        chk("rel_m0_ack_early", m0_ack, 0);
        @(posedge clk); #1;
        chk("rel_m0_ack", m0_ack, 1);
        chk("rel_m0_rdata", m0_rdata, 32'd8);
        m0_req = 1'b0;
        @(posedge clk); #1;

        for (int unsigned i = 0; i < 9; i++) run_txn(vecs[i]);
        chk("mem5_written", mem[5], 32'hDEADBEEF);

        // Contention: fresh reset so master 0 wins first
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd81; m0_wdata = '0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd83; m1_wdata = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            @(posedge clk);
            @(posedge clk); #1;
            chk("rr_m0_ack", m0_ack, (k % 2) == 0);
            chk("rr_m1_ack", m1_ack, (k % 2) == 1);
            chk("rr_rdata", (k % 2) == 0 ? m0_rdata : m1_rdata, (k % 2) == 0 ? 32'd44 : 32'hFFFFFF86);
            chk("fp_m0_ack", fp_m0_ack, 1);
            chk("fp_m1_ack", fp_m1_ack, 0);
            chk("fp_m0_rdata", fp_m0_rdata, 32'd44);
            chk("fp_m1_rdata", fp_m1_rdata, 0);
            chk("fp_errs", {fp_m0_err, fp_m1_err}, 0);
            chk("fp_grant_busy", {fp_grant_id, fp_busy}, 2'b01);
            chk("fp_mem_ctl", {fp_mem_memRead, fp_mem_memWrite}, 0);
            chk("fp_mem_dataIn", fp_mem_dataIn, 0);
            @(posedge clk);
        end
        #1; m0_req = 1'b0; m1_req = 1'b0;
        @(posedge clk); #1;

        // Reset during the ACCESS cycle of a write
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'd10; m0_wdata = 32'h99;
        @(posedge clk); #1;
        chk("midrst_memWrite_before", mem_memWrite, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_memWrite_async", mem_memWrite, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk); #1;
        chk("midrst_no_ack", m0_ack, 0);
        m0_req = 1'b0;
        @(posedge clk); #1;
        chk("midrst_no_ack2", m0_ack, 0);
        chk("midrst_mem10", mem[10], 32'd7);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", {busy, m0_ack, m1_ack}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
